// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster constants, pixel formats and the RGB565 -> RGB888 expansion.
package video_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam bit VGA_SYNC_POL   = 1'b0;
    localparam int DEF_SCALE      = 2;
    localparam int DEF_ADDR_W     = 17;
    localparam int DEF_RD_LATENCY = 1;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Sync flags mean "asserted"; the pin level is applied only at the output.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic frame_start;
    } raster_ctrl_t;

    // Replicating the MSBs keeps full-scale 565 values at full-scale 888.
    function automatic rgb888_t rgb565_to_888(input rgb565_t c);
        rgb888_t o;
        o.r = {c.r, c.r[4:2]};
        o.g = {c.g, c.g[5:4]};
        o.b = {c.b, c.b[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with active, sync and frame-start flags for the current position.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
)(
    input  logic         clk,
    input  logic         reset,
    output raster_ctrl_t ctrl,
    output logic         line_end,
    output logic         frame_end,
    output logic         line_active
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    logic [HW-1:0] h_cnt_reg, h_cnt_next;
    logic [VW-1:0] v_cnt_reg, v_cnt_next;
    logic          h_last, v_last;

    always_comb begin
        h_last     = (h_cnt_reg == HW'(H_TOTAL - 1));
        v_last     = (v_cnt_reg == VW'(V_TOTAL - 1));
        h_cnt_next = h_last ? '0 : h_cnt_reg + HW'(1);
        v_cnt_next = v_cnt_reg;
        if (h_last) begin
            v_cnt_next = v_last ? '0 : v_cnt_reg + VW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    always_comb begin
        line_active      = (v_cnt_reg < VW'(V_ACTIVE));
        ctrl.active      = (h_cnt_reg < HW'(H_ACTIVE)) && line_active;
        ctrl.hsync       = (h_cnt_reg >= HW'(H_ACTIVE + H_FP)) &&
                           (h_cnt_reg <  HW'(H_ACTIVE + H_FP + H_SYNC));
        ctrl.vsync       = (v_cnt_reg >= VW'(V_ACTIVE + V_FP)) &&
                           (v_cnt_reg <  VW'(V_ACTIVE + V_FP + V_SYNC));
        ctrl.frame_start = (h_cnt_reg == '0) && (v_cnt_reg == '0);
        line_end         = h_last;
        frame_end        = h_last && v_last;
    end

endmodule

// File: rtl/frame_buffer_reader.sv
// Scans a SCALE-reduced frame buffer into a pixel-doubled raster with aligned RGB888 and sync outputs.
module frame_buffer_reader
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit SYNC_POL   = VGA_SYNC_POL,
    parameter int SCALE      = DEF_SCALE,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int RD_LATENCY = DEF_RD_LATENCY
)(
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [15:0]       rd_data,
    output logic [23:0]       pix_out,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);
    localparam int PIPE  = RD_LATENCY + 2;
    localparam int SRC_W = H_ACTIVE / SCALE;
    localparam int XW    = $clog2(SRC_W + 1);
    localparam int SW    = $clog2(SCALE + 1);

    raster_ctrl_t ctrl0;
    logic         line_end, frame_end, line_active;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .ctrl        (ctrl0),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .line_active (line_active)
    );

    // Source coordinates advance with the raster; line_base replaces a y*SRC_W multiply.
    logic [XW-1:0]     src_x_reg, src_x_next;
    logic [SW-1:0]     x_rep_reg, x_rep_next;
    logic [SW-1:0]     y_rep_reg, y_rep_next;
    logic [ADDR_W-1:0] line_base_reg, line_base_next;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              rd_en_reg;

    always_comb begin
        src_x_next     = src_x_reg;
        x_rep_next     = x_rep_reg;
        y_rep_next     = y_rep_reg;
        line_base_next = line_base_reg;
        if (ctrl0.active) begin
            if (x_rep_reg == SW'(SCALE - 1)) begin
                x_rep_next = '0;
                src_x_next = src_x_reg + XW'(1);
            end else begin
                x_rep_next = x_rep_reg + SW'(1);
            end
        end
        if (line_end) begin
            src_x_next = '0;
            x_rep_next = '0;
            if (frame_end) begin
                y_rep_next     = '0;
                line_base_next = '0;
            end else if (line_active) begin
                if (y_rep_reg == SW'(SCALE - 1)) begin
                    y_rep_next     = '0;
                    line_base_next = line_base_reg + ADDR_W'(SRC_W);
                end else begin
                    y_rep_next = y_rep_reg + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_x_reg     <= '0;
            x_rep_reg     <= '0;
            y_rep_reg     <= '0;
            line_base_reg <= '0;
            rd_addr_reg   <= '0;
            rd_en_reg     <= 1'b0;
        end else begin
            src_x_reg     <= src_x_next;
            x_rep_reg     <= x_rep_next;
            y_rep_reg     <= y_rep_next;
            line_base_reg <= line_base_next;
            rd_en_reg     <= ctrl0.active;
            if (ctrl0.active) begin
                rd_addr_reg <= line_base_reg + ADDR_W'(src_x_reg);
            end
        end
    end

    assign rd_addr = rd_addr_reg;
    assign rd_en   = rd_en_reg;

    // Control flags travel alongside the read so the last stage lines up with pixel data.
    genvar gi;
    for (gi = 0; gi < PIPE; gi++) begin : g_delay
        raster_ctrl_t stage_in;
        raster_ctrl_t stage_reg;
        if (gi == 0) begin : g_head
            assign stage_in = ctrl0;
        end else begin : g_tail
            assign stage_in = g_delay[gi-1].stage_reg;
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                stage_reg <= '0;
            end else begin
                stage_reg <= stage_in;
            end
        end
    end

    logic [23:0]  pix_reg;
    raster_ctrl_t out_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_reg <= '0;
        end else if (g_delay[PIPE-2].stage_reg.active) begin
            pix_reg <= rgb565_to_888(rgb565_t'(rd_data));
        end else begin
            pix_reg <= '0;
        end
    end

    assign out_ctrl    = g_delay[PIPE-1].stage_reg;
    assign pix_out     = pix_reg;
    assign de          = out_ctrl.active;
    assign hsync       = out_ctrl.hsync ? SYNC_POL : ~SYNC_POL;
    assign vsync       = out_ctrl.vsync ? SYNC_POL : ~SYNC_POL;
    assign frame_start = out_ctrl.frame_start;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench: a full 640x480 reader (RD_LATENCY=1) and a reduced raster reader (RD_LATENCY=3) side by side.
module tb_frame_buffer_reader;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [16:0] rd_addr_f, rd_addr_s;
    logic        rd_en_f, rd_en_s;
    logic [15:0] rd_data_f, rd_data_s;
    logic [23:0] pix_f, pix_s;
    logic        de_f, hs_f, vs_f, fs_f;
    logic        de_s, hs_s, vs_s, fs_s;
    logic [15:0] mem_s [0:2];

    frame_buffer_reader dut_full (
        .clk (clk), .reset (reset), .rd_addr (rd_addr_f), .rd_en (rd_en_f), .rd_data (rd_data_f),
        .pix_out (pix_f), .de (de_f), .hsync (hs_f), .vsync (vs_f), .frame_start (fs_f)
    );

    // Reduced raster: 16 clocks x 8 lines, source 4x2, so whole frames fit in a short run.
    frame_buffer_reader #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .RD_LATENCY (3)
    ) dut_small (
        .clk (clk), .reset (reset), .rd_addr (rd_addr_s), .rd_en (rd_en_s), .rd_data (rd_data_s),
        .pix_out (pix_s), .de (de_s), .hsync (hs_s), .vsync (vs_s), .frame_start (fs_s)
    );

    function automatic logic [15:0] word_of(input logic [16:0] a);
        case (a[1:0])
            2'd0:    return 16'hF800;
            2'd1:    return 16'h07E0;
            2'd2:    return 16'h001F;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [23:0] colour_of(input int a);
        case (a % 4)
            0:       return 24'hFF0000;
            1:       return 24'h00FF00;
            2:       return 24'h0000FF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // Memory models return junk when not enabled so ignored data is visible.
    always @(posedge clk) begin
        rd_data_f <= rd_en_f ? word_of(rd_addr_f) : 16'h1234;
        mem_s[0]  <= rd_en_s ? word_of(rd_addr_s) : 16'h1234;
        mem_s[1]  <= mem_s[0];
        mem_s[2]  <= mem_s[1];
    end
    assign rd_data_s = mem_s[2];

    int checks = 0;
    int failures = 0;
    int err_addr_f = 0, err_out_f = 0, err_addr_s = 0, err_out_s = 0;
    int de_line0_f, de_rise_f, hs_first_f, hs_low_f, fs_count_f;
    int de_rise_s, vs_first_s, vs_low_s, fs_count_s, fs_k0_s, fs_k1_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_expect(input int k, input int hact, input int htot, input int vact,
                               input int vtot, input int src_w, output logic en, output int addr);
        int h, v;
        h = k % htot;
        v = (k / htot) % vtot;
        en = (h < hact) && (v < vact);
        addr = (v / 2) * src_w + h / 2;
    endtask

    task automatic out_expect(input int p, input int hact, input int hfp, input int hsw, input int htot,
                              input int vact, input int vfp, input int vsw, input int vtot, input int src_w,
                              output logic act, output logic hs, output logic vs, output logic fs,
                              output logic [23:0] pix);
        int h, v;
        act = 1'b0; hs = 1'b1; vs = 1'b1; fs = 1'b0; pix = 24'h0;
        if (p >= 0) begin
            h   = p % htot;
            v   = (p / htot) % vtot;
            act = (h < hact) && (v < vact);
            hs  = !((h >= hact + hfp) && (h < hact + hfp + hsw));
            vs  = !((v >= vact + vfp) && (v < vact + vfp + vsw));
            fs  = (h == 0) && (v == 0);
            pix = act ? colour_of((v / 2) * src_w + h / 2) : 24'h0;
        end
    endtask

    task automatic chk_reset_vals(input string when);
        chk({when, "_rd_addr_f"}, rd_addr_f, 0);
        chk({when, "_rd_en_f"}, rd_en_f, 0);
        chk({when, "_de_f"}, de_f, 0);
        chk({when, "_pix_f"}, pix_f, 0);
        chk({when, "_hsync_f"}, hs_f, 1);
        chk({when, "_vsync_f"}, vs_f, 1);
        chk({when, "_fs_f"}, fs_f, 0);
        chk({when, "_rd_addr_s"}, rd_addr_s, 0);
        chk({when, "_rd_en_s"}, rd_en_s, 0);
        chk({when, "_de_s"}, de_s, 0);
        chk({when, "_hsync_s"}, hs_s, 1);
        chk({when, "_vsync_s"}, vs_s, 1);
    endtask

    // k = index of the clock edge since reset was released; sampled on the following negedge.
    task automatic run_raster(input int n);
        logic e_en, e_act, e_hs, e_vs, e_fs;
        logic [23:0] e_pix;
        int e_addr;
        de_line0_f = 0; de_rise_f = -1; hs_first_f = -1; hs_low_f = 0; fs_count_f = 0;
        de_rise_s = -1; vs_first_s = -1; vs_low_s = 0; fs_count_s = 0; fs_k0_s = -1; fs_k1_s = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            read_expect(k, 640, 800, 480, 525, 320, e_en, e_addr);
            if (e_en ? (rd_en_f !== 1'b1 || rd_addr_f !== 17'(e_addr)) : (rd_en_f !== 1'b0)) err_addr_f++;
            out_expect(k - 2, 640, 16, 96, 800, 480, 10, 2, 525, 320, e_act, e_hs, e_vs, e_fs, e_pix);
            if ({de_f, hs_f, vs_f, fs_f} !== {e_act, e_hs, e_vs, e_fs} || pix_f !== e_pix) err_out_f++;

            read_expect(k, 8, 16, 4, 8, 4, e_en, e_addr);
            if (e_en ? (rd_en_s !== 1'b1 || rd_addr_s !== 17'(e_addr)) : (rd_en_s !== 1'b0)) err_addr_s++;
            out_expect(k - 4, 8, 2, 3, 16, 4, 1, 2, 8, 4, e_act, e_hs, e_vs, e_fs, e_pix);
            if ({de_s, hs_s, vs_s, fs_s} !== {e_act, e_hs, e_vs, e_fs} || pix_s !== e_pix) err_out_s++;

            if (de_f === 1'b1 && de_rise_f < 0) de_rise_f = k;
            if (de_f === 1'b1 && k - 2 < 800) de_line0_f++;
            if (hs_f === 1'b0) begin
                hs_low_f++;
                if (hs_first_f < 0) hs_first_f = k;
            end
            if (fs_f === 1'b1) fs_count_f++;
            if (de_s === 1'b1 && de_rise_s < 0) de_rise_s = k;
            if (vs_s === 1'b0) begin
                if (k - 4 < 128) vs_low_s++;
                if (vs_first_s < 0) vs_first_s = k;
            end
            if (fs_s === 1'b1) begin
                fs_count_s++;
                if (fs_k0_s < 0) fs_k0_s = k;
                else if (fs_k1_s < 0) fs_k1_s = k;
            end

            if (k == 0) begin
                chk("start_rd_en_f", rd_en_f, 1);
                chk("start_rd_addr_f", rd_addr_f, 0);
                chk("start_rd_en_s", rd_en_s, 1);
                chk("start_rd_addr_s", rd_addr_s, 0);
            end
            if (k == 1) chk("de_f_not_yet", de_f, 0);
            if (k == 2) begin
                chk("de_f_first", de_f, 1);
                chk("fs_f_first", fs_f, 1);
                chk("pix_f_red", pix_f, 24'hFF0000);
            end
            if (k == 3) begin
                chk("de_s_not_yet", de_s, 0);
                chk("fs_f_single", fs_f, 0);
            end
            if (k == 4) begin
                chk("de_s_first", de_s, 1);
                chk("fs_s_first", fs_s, 1);
                chk("pix_f_green", pix_f, 24'h00FF00);
                chk("pix_s_red", pix_s, 24'hFF0000);
            end
            if (k == 6) chk("pix_f_blue", pix_f, 24'h0000FF);
            if (k == 8) chk("pix_f_white", pix_f, 24'hFFFFFF);
            if (k == 55) chk("small_last_addr", rd_addr_s, 7);
            if (k == 100) begin
                chk("small_blank_hold_addr", rd_addr_s, 7);
                chk("small_blank_rd_en", rd_en_s, 0);
            end
            if (k == 128) begin
                chk("small_next_frame_addr", rd_addr_s, 0);
                chk("small_next_frame_rd_en", rd_en_s, 1);
            end
            if (k == 700) begin
                chk("full_blank_hold_addr", rd_addr_f, 319);
                chk("full_blank_rd_en", rd_en_f, 0);
            end
            if (k == 1000) chk("full_line1_addr", rd_addr_f, 100);
            if (k == 1600) chk("full_line2_addr", rd_addr_f, 320);
        end
    endtask

    initial begin
        repeat (10) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        run_raster(2465);

        chk("full_de_per_line", de_line0_f, 640);
        chk("full_hsync_offset", hs_first_f - de_rise_f, 656);
        chk("full_hsync_low_3lines", hs_low_f, 288);
        chk("full_fs_count", fs_count_f, 1);
        chk("small_fs_period", fs_k1_s - fs_k0_s, 128);
        chk("small_fs_count", fs_count_s, 20);
        chk("small_vsync_offset", vs_first_s - de_rise_s, 80);
        chk("small_vsync_low", vs_low_s, 32);

        // Mid-frame: full is inside line 3 active, small is in hsync of line 1.
        chk("pre_reset_de_f", de_f, 1);
        chk("pre_reset_hsync_s", hs_s, 0);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midframe");
        reset = 1'b0;
        run_raster(10);

        chk("addr_model_full", err_addr_f, 0);
        chk("out_model_full", err_out_f, 0);
        chk("addr_model_small", err_addr_s, 0);
        chk("out_model_small", err_out_s, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
